// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: register-number type, Tnew width and
// the saturating Tnew decrement used by the D/E, E/M and M/W stage registers.
package pipe_pkg;

    localparam int unsigned TW = 4;

    typedef logic [4:0] reg_num_t;

    localparam reg_num_t REG_ZERO = 5'd0;

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Parameterised pipeline field flop: async active-low reset, clear (loads
// clr_val) taking priority over enable, otherwise hold.
module pipe_field_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] clr_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= clr_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_e_stage_reg.sv
// Decode/Execute pipeline register with hold (en=0) and bubble (clear=1).
// Optional bubble counter output enabled by defining DE_BUBBLE_CNT_EN.
module d_e_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned TW = pipe_pkg::TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic [DW-1:0] d_pc,
    input  logic [DW-1:0] d_instr,
    input  logic [DW-1:0] d_rs_data,
    input  logic [DW-1:0] d_rt_data,
    input  logic [DW-1:0] d_ext,
    input  logic [4:0]    d_a1,
    input  logic [4:0]    d_a2,
    input  logic [4:0]    d_a3,
    input  logic          d_regwrite,
    input  logic [TW-1:0] d_tnew,
    output logic [DW-1:0] e_pc,
    output logic [DW-1:0] e_instr,
    output logic [DW-1:0] e_rs_data,
    output logic [DW-1:0] e_rt_data,
    output logic [DW-1:0] e_ext,
    output logic [4:0]    e_a1,
    output logic [4:0]    e_a2,
    output logic [4:0]    e_a3,
    output logic          e_regwrite,
    output logic [TW-1:0] e_tnew,
    output logic          e_valid
`ifdef DE_BUBBLE_CNT_EN
    ,
    output logic [31:0]   bubble_cnt
`endif
);

    localparam int unsigned DATA_W = 4 * DW;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned CTRL_W = TW + 2;

    logic          regwrite_eff;
    logic [TW-1:0] tnew_next;

    // A $0 destination can never be written, so it never creates a hazard.
    assign regwrite_eff = d_regwrite && (reg_num_t'(d_a3) != REG_ZERO);
    assign tnew_next    = tnew_dec(d_tnew);

    // PC survives a bubble so the slot can still be traced.
    pipe_field_reg #(.W(DW)) u_pc (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clear   (clear),
        .clr_val (d_pc),
        .d       (d_pc),
        .q       (e_pc)
    );

    pipe_field_reg #(.W(DATA_W)) u_data (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clear   (clear),
        .clr_val ('0),
        .d       ({d_instr, d_rs_data, d_rt_data, d_ext}),
        .q       ({e_instr, e_rs_data, e_rt_data, e_ext})
    );

    pipe_field_reg #(.W(ADDR_W)) u_addr (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clear   (clear),
        .clr_val ('0),
        .d       ({d_a1, d_a2, d_a3}),
        .q       ({e_a1, e_a2, e_a3})
    );

    pipe_field_reg #(.W(CTRL_W)) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clear   (clear),
        .clr_val ('0),
        .d       ({regwrite_eff, tnew_next, 1'b1}),
        .q       ({e_regwrite, e_tnew, e_valid})
    );

`ifdef DE_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (clear) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_e_stage_reg.sv
// Self-checking bench for d_e_stage_reg: vector table plus reset/hold
// sequences, expected outputs queued by a reference model.
module tb_d_e_stage_reg;

    typedef struct packed {
        logic        clear;
        logic        en;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        regwrite;
        logic [3:0]  tnew;
    } in_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        regwrite;
        logic [3:0]  tnew;
        logic        valid;
    } out_t;

    typedef struct packed {
        in_t        in;
        logic       x_regwrite;
        logic [3:0] x_tnew;
        logic       x_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] d_pc = '0, d_instr = '0, d_rs_data = '0, d_rt_data = '0, d_ext = '0;
    logic [4:0]  d_a1 = '0, d_a2 = '0, d_a3 = '0;
    logic        d_regwrite = 1'b0;
    logic [3:0]  d_tnew = '0;
    logic [31:0] e_pc, e_instr, e_rs_data, e_rt_data, e_ext;
    logic [4:0]  e_a1, e_a2, e_a3;
    logic        e_regwrite;
    logic [3:0]  e_tnew;
    logic        e_valid;
`ifdef DE_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int unsigned nchecks = 0;
    int unsigned nerrors = 0;
    out_t        sb[$];
    out_t        model_q = '0;
    logic [31:0] model_bcnt = '0;
    vec_t        tbl[10];

    d_e_stage_reg #(.DW(32), .TW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clear      (clear),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_rs_data  (d_rs_data),
        .d_rt_data  (d_rt_data),
        .d_ext      (d_ext),
        .d_a1       (d_a1),
        .d_a2       (d_a2),
        .d_a3       (d_a3),
        .d_regwrite (d_regwrite),
        .d_tnew     (d_tnew),
        .e_pc       (e_pc),
        .e_instr    (e_instr),
        .e_rs_data  (e_rs_data),
        .e_rt_data  (e_rt_data),
        .e_ext      (e_ext),
        .e_a1       (e_a1),
        .e_a2       (e_a2),
        .e_a3       (e_a3),
        .e_regwrite (e_regwrite),
        .e_tnew     (e_tnew),
        .e_valid    (e_valid)
`ifdef DE_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic in_t mk(logic c, logic e, logic [31:0] pc, logic [4:0] a3,
                               logic rw, logic [3:0] tn);
        in_t v;
        v.clear    = c;
        v.en       = e;
        v.pc       = pc;
        v.instr    = pc ^ 32'hA5A5_0F0F;
        v.rs       = pc + 32'h1111_0000;
        v.rt       = ~pc;
        v.ext      = {pc[15:0], pc[31:16]};
        v.a1       = pc[6:2];
        v.a2       = pc[11:7] ^ 5'h15;
        v.a3       = a3;
        v.regwrite = rw;
        v.tnew     = tn;
        return v;
    endfunction

    function automatic out_t model(out_t p, in_t v);
        out_t n = p;
        if (v.clear) begin
            n    = '0;
            n.pc = v.pc;
        end else if (v.en) begin
            n.pc       = v.pc;
            n.instr    = v.instr;
            n.rs       = v.rs;
            n.rt       = v.rt;
            n.ext      = v.ext;
            n.a1       = v.a1;
            n.a2       = v.a2;
            n.a3       = v.a3;
            n.regwrite = v.regwrite && (v.a3 != 5'd0);
            n.tnew     = (v.tnew == 4'd0) ? 4'd0 : v.tnew - 4'd1;
            n.valid    = 1'b1;
        end
        return n;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.pc = e_pc; o.instr = e_instr; o.rs = e_rs_data; o.rt = e_rt_data;
        o.ext = e_ext; o.a1 = e_a1; o.a2 = e_a2; o.a3 = e_a3;
        o.regwrite = e_regwrite; o.tnew = e_tnew; o.valid = e_valid;
        return o;
    endfunction

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive(input in_t v);
        clear = v.clear; en = v.en; d_pc = v.pc; d_instr = v.instr;
        d_rs_data = v.rs; d_rt_data = v.rt; d_ext = v.ext;
        d_a1 = v.a1; d_a2 = v.a2; d_a3 = v.a3;
        d_regwrite = v.regwrite; d_tnew = v.tnew;
    endtask

    // Drive at negedge, queue model result, compare #1 after the capturing edge.
    task automatic step(input string name, input in_t v);
        out_t e;
        out_t g;
        @(negedge clk);
        drive(v);
        model_q = model(model_q, v);
        if (v.clear) model_bcnt = model_bcnt + 32'd1;
        sb.push_back(model_q);
        @(posedge clk);
        #1;
        g = dut_out();
        e = sb.pop_front();
        chk(name, 192'(g), 192'(e));
`ifdef DE_BUBBLE_CNT_EN
        chk({name, "_bcnt"}, 192'(bubble_cnt), 192'(model_bcnt));
`endif
    endtask

    initial begin
        tbl[0] = '{mk(0, 1, 32'h0000_3010, 5'd5,  1, 4'd2), 1'b1, 4'd1, 1'b1};
        tbl[1] = '{mk(0, 1, 32'h0000_3014, 5'd3,  1, 4'd0), 1'b1, 4'd0, 1'b1};
        tbl[2] = '{mk(0, 1, 32'h0000_3018, 5'd7,  1, 4'hF), 1'b1, 4'hE, 1'b1};
        tbl[3] = '{mk(0, 1, 32'h0000_301C, 5'd0,  1, 4'd1), 1'b0, 4'd0, 1'b1};
        tbl[4] = '{mk(0, 1, 32'h0000_3020, 5'd8,  1, 4'd1), 1'b1, 4'd0, 1'b1};
        tbl[5] = '{mk(1, 1, 32'h0000_3004, 5'd9,  1, 4'd3), 1'b0, 4'd0, 1'b0};
        tbl[6] = '{mk(1, 0, 32'h0000_3024, 5'd10, 1, 4'd2), 1'b0, 4'd0, 1'b0};
        tbl[7] = '{mk(0, 1, 32'h0000_3028, 5'd31, 0, 4'd1), 1'b0, 4'd0, 1'b1};
        tbl[8] = '{mk(0, 1, 32'h0000_302C, 5'd4,  1, 4'd3), 1'b1, 4'd2, 1'b1};
        tbl[9] = '{mk(0, 0, 32'h0000_3030, 5'd0,  0, 4'd7), 1'b1, 4'd2, 1'b1};

        // Reset held with random inputs: everything must read zero.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(mk(1'($urandom), 1'($urandom), $urandom, 5'($urandom), 1'($urandom), 4'($urandom)));
            @(posedge clk);
            #1;
            chk("reset_outputs", 192'(dut_out()), 192'd0);
`ifdef DE_BUBBLE_CNT_EN
            chk("reset_bcnt", 192'(bubble_cnt), 192'd0);
`endif
        end
        model_q = '0;
        model_bcnt = '0;

        @(negedge clk);
        reset = 1'b1;
        step("reset_release", mk(0, 1, 32'h0000_3000, 5'd2, 1, 4'd2));
        chk("release_pc", 192'(e_pc), 192'(32'h0000_3000));
        chk("release_tnew", 192'(e_tnew), 192'(4'd1));
        chk("release_valid", 192'(e_valid), 192'(1'b1));

        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), tbl[i].in);
            chk($sformatf("vec%0d_key", i), 192'({e_regwrite, e_tnew, e_valid}),
                192'({tbl[i].x_regwrite, tbl[i].x_tnew, tbl[i].x_valid}));
        end
        chk("bubble_pc_kept", 192'(e_pc), 192'(32'h0000_302C));

        // Hold: tnew captured as 2 must not keep decrementing.
        step("hold_capture", mk(0, 1, 32'h0000_3100, 5'd12, 1, 4'd3));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i),
                 mk(0, 0, 32'h0000_3200 + 32'(i * 4), 5'(i + 1), 1'(i), 4'(i + 5)));
            chk($sformatf("hold%0d_tnew", i), 192'(e_tnew), 192'(4'd2));
        end

        // Async reset pulse between edges during a hold.
        @(negedge clk);
        drive(mk(0, 0, 32'h0000_3300, 5'd6, 1, 4'd4));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", 192'(dut_out()), 192'd0);
`ifdef DE_BUBBLE_CNT_EN
        chk("async_reset_bcnt", 192'(bubble_cnt), 192'd0);
`endif
        model_q = '0;
        model_bcnt = '0;
        @(posedge clk);
        #1;
        chk("reset_across_edge", 192'(dut_out()), 192'd0);
        @(negedge clk);
        reset = 1'b1;
        step("post_reset_capture", mk(0, 1, 32'h0000_3400, 5'd17, 1, 4'd1));
        step("post_reset_bubble", mk(1, 0, 32'h0000_3404, 5'd18, 1, 4'd2));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
